// File: rtl/fb_plot_if.sv
`default_nettype none
// ============================================================================
// fb_plot_if
//   Pixel-plot, clear-control and framebuffer write-port signal bundle.
//   Revision 1.0
// ============================================================================
interface fb_plot_if;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [11:0] colour;
  logic        plot;
  logic        plot_ready;
  logic        clear_req;
  logic [11:0] clear_colour;
  logic        clear_busy;
  logic        clear_done;
  logic        mem_grant;
  logic [16:0] mem_addr;
  logic [11:0] mem_data;
  logic        mem_wren;
  logic [7:0]  drop_count;

  modport master (
    output x, y, colour, plot, clear_req, clear_colour, mem_grant,
    input  plot_ready, clear_busy, clear_done, mem_addr, mem_data, mem_wren, drop_count
  );

  modport slave (
    input  x, y, colour, plot, clear_req, clear_colour, mem_grant,
    output plot_ready, clear_busy, clear_done, mem_addr, mem_data, mem_wren, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/fb_plot_writer.sv
`default_nettype none
// ============================================================================
// fb_plot_writer
//   Buffers and clips pixel plots, writes a linear framebuffer on grant, and
//   performs full-screen clears.
//   Revision 1.0
// ============================================================================
module fb_plot_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_RES      = 320,
  parameter int V_RES      = 240
) (
  input  logic     CLOCK_50,
  input  logic     resetn,
  fb_plot_if.slave bus
);
  localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [16:0] LAST_ADDR = 17'(H_RES * V_RES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]       state;
  logic [16:0]      fifo_addr [FIFO_DEPTH];
  logic [11:0]      fifo_col  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [16:0]      clr_cnt;
  logic [11:0]      clr_colour;
  logic             clear_busy;
  logic             clear_done;
  logic             mem_wren;
  logic [16:0]      mem_addr;
  logic [11:0]      mem_data;
  logic [7:0]       drop_count;

  logic        fifo_full;
  logic        fifo_empty;
  logic        plot_ready;
  logic        accept;
  logic        in_range;
  logic        push;
  logic        pop;
  logic        clr_wr;
  logic        start_clear;
  logic [16:0] plot_addr;

  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count == '0);
  // DRAIN is the "clear pending" phase: no new plots until the clear is done.
  assign plot_ready  = !fifo_full && (state != ST_CLEAR) && (state != ST_DRAIN);
  assign accept      = bus.plot && plot_ready;
  assign in_range    = (17'(bus.x) < 17'(H_RES)) && (17'(bus.y) < 17'(V_RES));
  assign push        = accept && in_range;
  assign pop         = !fifo_empty && bus.mem_grant && (state != ST_CLEAR);
  assign clr_wr      = (state == ST_CLEAR) && bus.mem_grant;
  assign start_clear = bus.clear_req && !clear_busy;
  assign plot_addr   = 17'(bus.y) * 17'(H_RES) + 17'(bus.x);

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      fifo_addr[wr_ptr] <= plot_addr;
      fifo_col[wr_ptr]  <= bus.colour;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (accept && !in_range && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      clr_colour <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_clear) begin
            clear_busy <= 1'b1;
            clr_colour <= bus.clear_colour;
            clr_cnt    <= '0;
            // A plot accepted on the same edge must be written first.
            state      <= (!fifo_empty || push) ? ST_DRAIN : ST_CLEAR;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (clr_wr) begin
            if (clr_cnt == LAST_ADDR) begin
              clr_cnt    <= '0;
              clear_done <= 1'b1;
              clear_busy <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              clr_cnt <= clr_cnt + 17'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mem_wren <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_wren <= pop || clr_wr;
      if (pop) begin
        mem_addr <= fifo_addr[rd_ptr];
        mem_data <= fifo_col[rd_ptr];
      end else if (clr_wr) begin
        mem_addr <= clr_cnt;
        mem_data <= clr_colour;
      end
    end
  end

  assign bus.plot_ready = plot_ready;
  assign bus.clear_busy = clear_busy;
  assign bus.clear_done = clear_done;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_data   = mem_data;
  assign bus.mem_wren   = mem_wren;
  assign bus.drop_count = drop_count;
endmodule
`default_nettype wire

// File: tb/tb_fb_plot_writer.sv
`default_nettype none
// ============================================================================
// tb_fb_plot_writer
//   Scoreboard bench: full-size instance for plots/clip/full clear, small
//   instance for grant-toggled clear and reset-abort.
//   Revision 1.0
// ============================================================================
module tb_fb_plot_writer;
  localparam int SH = 20;
  localparam int SV = 10;

  logic clk;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;
  int   wr_a = 0, wr_b = 0, done_a = 0, done_b = 0;
  logic [28:0] exp_a[$];
  logic [28:0] exp_b[$];

  fb_plot_if a_if ();
  fb_plot_if b_if ();

  fb_plot_writer u_a (.CLOCK_50(clk), .resetn(resetn), .bus(a_if.slave));
  fb_plot_writer #(.FIFO_DEPTH(4), .H_RES(SH), .V_RES(SV))
    u_b (.CLOCK_50(clk), .resetn(resetn), .bus(b_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    logic [28:0] e;
    if (a_if.mem_wren === 1'b1) begin
      wr_a++;
      if (exp_a.size() == 0) check("a_unexpected_write", {3'd0, a_if.mem_addr, a_if.mem_data}, 32'hFFFF_FFFF);
      else begin
        e = exp_a.pop_front();
        check("a_write", {3'd0, a_if.mem_addr, a_if.mem_data}, {3'd0, e});
      end
    end
    if (a_if.clear_done === 1'b1) done_a++;
  end

  always @(negedge clk) begin : mon_b
    logic [28:0] e;
    if (b_if.mem_wren === 1'b1) begin
      wr_b++;
      if (exp_b.size() == 0) check("b_unexpected_write", {3'd0, b_if.mem_addr, b_if.mem_data}, 32'hFFFF_FFFF);
      else begin
        e = exp_b.pop_front();
        check("b_write", {3'd0, b_if.mem_addr, b_if.mem_data}, {3'd0, e});
      end
    end
    if (b_if.clear_done === 1'b1) done_b++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input bit sb, input int px, input int py, input logic [11:0] pc);
    int  guard;
    logic rdy;
    int  h, v;
    h = sb ? SH : 320;
    v = sb ? SV : 240;
    if (sb) begin b_if.x = 9'(px); b_if.y = 8'(py); b_if.colour = pc; b_if.plot = 1'b1; end
    else    begin a_if.x = 9'(px); a_if.y = 8'(py); a_if.colour = pc; a_if.plot = 1'b1; end
    guard = 0;
    rdy = sb ? b_if.plot_ready : a_if.plot_ready;
    while (!rdy && guard < 200) begin
      tick(1); guard++;
      rdy = sb ? b_if.plot_ready : a_if.plot_ready;
    end
    if (!rdy) check("plot_ready_timeout", 32'd0, 32'd1);
    if (px < h && py < v) begin
      if (sb) exp_b.push_back({17'(py * h + px), pc});
      else    exp_a.push_back({17'(py * h + px), pc});
    end
    tick(1);
    if (sb) b_if.plot = 1'b0; else a_if.plot = 1'b0;
  endtask

  task automatic push_clear(input bit sb, input int n, input logic [11:0] c);
    for (int i = 0; i < n; i++) begin
      if (sb) exp_b.push_back({17'(i), c});
      else    exp_a.push_back({17'(i), c});
    end
  endtask

  task automatic wait_empty(input bit sb, input int budget, input string name);
    int g;
    g = 0;
    while ((sb ? exp_b.size() : exp_a.size()) != 0 && g < budget) begin
      tick(1); g++;
    end
    check(name, 32'((sb ? exp_b.size() : exp_a.size())), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int g;
    resetn = 1'b0;
    a_if.x = '0; a_if.y = '0; a_if.colour = '0; a_if.plot = 1'b0;
    a_if.clear_req = 1'b0; a_if.clear_colour = '0; a_if.mem_grant = 1'b0;
    b_if.x = '0; b_if.y = '0; b_if.colour = '0; b_if.plot = 1'b0;
    b_if.clear_req = 1'b0; b_if.clear_colour = '0; b_if.mem_grant = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(1);
    check("rst_plot_ready", 32'(a_if.plot_ready), 32'd1);
    check("rst_wren",       32'(a_if.mem_wren),   32'd0);
    check("rst_busy",       32'(a_if.clear_busy), 32'd0);
    check("rst_drop",       32'(a_if.drop_count), 32'd0);
    check("rst_addr",       32'(a_if.mem_addr),   32'd0);

    // single plot, latency of two edges
    a_if.mem_grant = 1'b1;
    send(1'b0, 5, 2, 12'hF00);
    @(posedge clk); @(negedge clk);
    check("t1_wren", 32'(a_if.mem_wren), 32'd1);
    check("t1_addr", 32'(a_if.mem_addr), 32'd645);
    check("t1_data", 32'(a_if.mem_data), 32'hF00);
    tick(2);

    // fill FIFO with grant low, then drain in order
    a_if.mem_grant = 1'b0;
    send(1'b0, 0, 0, 12'h001);
    send(1'b0, 1, 0, 12'h002);
    send(1'b0, 0, 1, 12'h003);
    send(1'b0, 100, 100, 12'h004);
    check("t2_full_not_ready", 32'(a_if.plot_ready), 32'd0);
    tick(3);
    check("t2_no_write_wo_grant", 32'(exp_a.size()), 32'd4);
    a_if.mem_grant = 1'b1;
    wait_empty(1'b0, 20, "t2_drain");
    check("t2_ready_again", 32'(a_if.plot_ready), 32'd1);

    // clipping and maximum address
    send(1'b0, 320, 0, 12'hABC);
    send(1'b0, 0, 240, 12'hABC);
    tick(3);
    check("t3_drop_count", 32'(a_if.drop_count), 32'd2);
    send(1'b0, 319, 239, 12'h0AB);
    wait_empty(1'b0, 10, "t3_max_addr");

    // queued plots then full-screen clear
    a_if.mem_grant = 1'b0;
    send(1'b0, 10, 0, 12'h111);
    send(1'b0, 0, 1, 12'h222);
    push_clear(1'b0, 76800, 12'h888);
    base = wr_a;
    a_if.clear_colour = 12'h888;
    a_if.clear_req = 1'b1;
    tick(1);
    a_if.clear_req = 1'b0;
    check("t4_busy_set", 32'(a_if.clear_busy), 32'd1);
    check("t4_not_ready", 32'(a_if.plot_ready), 32'd0);
    a_if.mem_grant = 1'b1;
    g = 0;
    while (done_a == 0 && g < 80000) begin tick(1); g++; end
    check("t4_done_seen", 32'(done_a), 32'd1);
    check("t4_busy_clear", 32'(a_if.clear_busy), 32'd0);
    check("t4_write_count", 32'(wr_a - base), 32'd76802);
    check("t4_queue_empty", 32'(exp_a.size()), 32'd0);
    tick(3);
    check("t4_single_done", 32'(done_a), 32'd1);
    check("t4_idle_ready", 32'(a_if.plot_ready), 32'd1);

    // small instance: clip count, plot+clear on same edge, toggling grant
    b_if.mem_grant = 1'b0;
    send(1'b1, SH, 0, 12'h777);
    tick(1);
    check("t5_drop", 32'(b_if.drop_count), 32'd1);
    base = wr_b;
    b_if.x = 9'd3; b_if.y = 8'd2; b_if.colour = 12'h0F0; b_if.plot = 1'b1;
    b_if.clear_colour = 12'hA5A; b_if.clear_req = 1'b1;
    exp_b.push_back({17'd43, 12'h0F0});
    push_clear(1'b1, SH * SV, 12'hA5A);
    tick(1);
    b_if.plot = 1'b0; b_if.clear_req = 1'b0;
    check("t5_busy_set", 32'(b_if.clear_busy), 32'd1);
    check("t5_not_ready", 32'(b_if.plot_ready), 32'd0);
    g = 0;
    while (done_b == 0 && g < 1000) begin
      b_if.mem_grant = ~b_if.mem_grant;
      if (g == 40) begin b_if.clear_req = 1'b1; b_if.clear_colour = 12'h111; end
      else b_if.clear_req = 1'b0;
      tick(1); g++;
    end
    b_if.clear_req = 1'b0;
    b_if.mem_grant = 1'b1;
    check("t5_done_seen", 32'(done_b), 32'd1);
    check("t5_busy_clear", 32'(b_if.clear_busy), 32'd0);
    check("t5_write_count", 32'(wr_b - base), 32'(SH * SV + 1));
    check("t5_queue_empty", 32'(exp_b.size()), 32'd0);
    tick(4);
    check("t5_single_done", 32'(done_b), 32'd1);

    // reset in the middle of a clear
    send(1'b1, SH + 3, 1, 12'h777);
    push_clear(1'b1, SH * SV, 12'h3C3);
    b_if.clear_colour = 12'h3C3; b_if.clear_req = 1'b1;
    tick(1);
    b_if.clear_req = 1'b0;
    tick(50);
    resetn = 1'b0;
    exp_b.delete();
    #1;
    check("t6_wren_async", 32'(b_if.mem_wren), 32'd0);
    check("t6_busy_async", 32'(b_if.clear_busy), 32'd0);
    tick(3);
    resetn = 1'b1;
    tick(1);
    check("t6_ready", 32'(b_if.plot_ready), 32'd1);
    check("t6_drop", 32'(b_if.drop_count), 32'd0);
    check("t6_busy", 32'(b_if.clear_busy), 32'd0);
    tick(4);
    check("t6_no_stray_write", 32'(exp_b.size()), 32'd0);
    send(1'b1, 1, 1, 12'h555);
    wait_empty(1'b1, 10, "t6_plot_after_reset");
    tick(3);
    check("t6_done_count", 32'(done_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
